// File: rtl/rep_code_serial_tx.sv
// Repetition-code serial transmitter: frames a parallel word with start/stop
// symbols and sends each symbol as REPEAT identical chips, with optional
// single-chip inversion per symbol for exercising the receiving voter.
module rep_code_serial_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REPEAT = 5,
    localparam int unsigned CW = $clog2(REPEAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              err_en,
    input  logic [CW-1:0]     err_chip,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_chip_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_err_en;
    logic [CW-1:0]     r_err_chip;
    logic              r_tx;
    logic              r_done;

    logic [1:0]        w_nxt_state;
    logic [CW-1:0]     w_nxt_chip;
    logic [BW-1:0]     w_nxt_bit;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_nxt_err_en;
    logic [CW-1:0]     w_nxt_err_chip;
    logic              w_nxt_sym;
    logic              w_nxt_tx;
    logic              w_nxt_done;
    logic              w_last_chip;

    // Next-state logic; the line level for the coming cycle is derived from
    // the next state so the first start chip follows the accepting edge.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_chip     = r_chip_cnt;
        w_nxt_bit      = r_bit_cnt;
        w_nxt_data     = r_data;
        w_nxt_err_en   = r_err_en;
        w_nxt_err_chip = r_err_chip;
        w_nxt_sym      = 1'b0;
        w_nxt_tx       = 1'b0;
        w_nxt_done     = 1'b0;
        w_last_chip    = (r_chip_cnt == CW'(REPEAT - 1));

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_nxt_state    = S_START;
                    w_nxt_chip     = '0;
                    w_nxt_bit      = '0;
                    w_nxt_data     = in_data;
                    w_nxt_err_en   = err_en;
                    w_nxt_err_chip = err_chip;
                end
            end
            S_START: begin
                if (w_last_chip) begin
                    w_nxt_state = S_DATA;
                    w_nxt_chip  = '0;
                    w_nxt_bit   = '0;
                end else begin
                    w_nxt_chip = r_chip_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_last_chip) begin
                    w_nxt_chip = '0;
                    if (r_bit_cnt == BW'(DATA_W - 1)) begin
                        w_nxt_state = S_STOP;
                    end else begin
                        w_nxt_bit  = r_bit_cnt + BW'(1);
                        w_nxt_data = r_data << 1;
                    end
                end else begin
                    w_nxt_chip = r_chip_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_last_chip) begin
                    w_nxt_state    = S_IDLE;
                    w_nxt_chip     = '0;
                    w_nxt_bit      = '0;
                    w_nxt_data     = '0;
                    w_nxt_err_en   = 1'b0;
                    w_nxt_err_chip = '0;
                end else begin
                    w_nxt_chip = r_chip_cnt + CW'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        case (w_nxt_state)
            S_START: w_nxt_sym = 1'b1;
            S_DATA:  w_nxt_sym = w_nxt_data[DATA_W-1];
            default: w_nxt_sym = 1'b0;
        endcase

        if (w_nxt_state != S_IDLE) begin
            w_nxt_tx = w_nxt_sym ^ (w_nxt_err_en && (w_nxt_chip == w_nxt_err_chip));
        end
        w_nxt_done = (w_nxt_state == S_STOP) && (w_nxt_chip == CW'(REPEAT - 1));
    end

    // State, counters, latched frame fields and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_chip_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_err_en   <= 1'b0;
            r_err_chip <= '0;
            r_tx       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_chip_cnt <= w_nxt_chip;
            r_bit_cnt  <= w_nxt_bit;
            r_data     <= w_nxt_data;
            r_err_en   <= w_nxt_err_en;
            r_err_chip <= w_nxt_err_chip;
            r_tx       <= w_nxt_tx;
            r_done     <= w_nxt_done;
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign tx_out   = r_tx;
    assign done     = r_done;

endmodule

// File: tb/tb_rep_code_serial_tx.sv
// Scoreboard bench for rep_code_serial_tx: stimulus pushes expected chips,
// a negedge monitor pops and compares while the block is busy.
module tb_rep_code_serial_tx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REPEAT = 5;
    localparam int unsigned CW     = $clog2(REPEAT);
    localparam int unsigned FLEN   = (DATA_W + 2) * REPEAT;

    typedef struct packed {
        logic tx;
        logic dn;
    } chip_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              err_en = 1'b0;
    logic [CW-1:0]     err_chip = '0;
    logic              tx_out;
    logic              busy;
    logic              done;

    chip_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    mon_en   = 1'b0;

    rep_code_serial_tx #(.DATA_W(DATA_W), .REPEAT(REPEAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .err_en   (err_en),
        .err_chip (err_chip),
        .tx_out   (tx_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_fail(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Frame model: start 1, data MSB-first, stop 0, REPEAT chips each.
    task automatic push_frame(input logic [DATA_W-1:0] d, input logic en, input int chip);
        logic sym;
        for (int s = 0; s < DATA_W + 2; s++) begin
            if (s == 0) sym = 1'b1;
            else if (s == DATA_W + 1) sym = 1'b0;
            else sym = d[DATA_W - s];
            for (int c = 0; c < REPEAT; c++) begin
                sb.push_back('{tx: sym ^ (en && (c == chip)),
                               dn: (s == DATA_W + 1) && (c == REPEAT - 1)});
            end
        end
    endtask

    // Hand-written 50-chip waveform, first chip in the MSB.
    task automatic push_vec(input logic [FLEN-1:0] v);
        for (int i = FLEN - 1; i >= 0; i--) begin
            sb.push_back('{tx: v[i], dn: (i == 0)});
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic en, input logic [CW-1:0] ch);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk_fail("send_ready_timeout");
        in_data = d; err_en = en; err_chip = ch; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (busy || sb.size() != 0) chk_fail("wait_idle_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every busy cycle against the scoreboard, idle cycles against 0.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (busy) begin
                if (sb.size() == 0) begin
                    chk_fail("unexpected_busy");
                end else begin
                    chip_t e;
                    e = sb.pop_front();
                    chk("tx_out", tx_out, e.tx);
                    chk("done", done, e.dn);
                    chk("in_ready_busy", in_ready, 1'b0);
                end
            end else begin
                chk("idle_tx", tx_out, 1'b0);
                chk("idle_done", done, 1'b0);
                chk("idle_ready", in_ready, 1'b1);
            end
        end
    end

    initial begin
        logic [FLEN-1:0] v_a5;
        logic [FLEN-1:0] v_3c;
        int t;
        v_a5 = 50'b11111_11111_00000_11111_00000_00000_11111_00000_11111_00000;
        v_3c = 50'b11011_00100_00100_11011_11011_11011_11011_00100_00100_00100;

        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("post_rst_idle", busy, 1'b0);

        // Plain frame, hand-computed waveform.
        push_vec(v_a5);
        send(8'hA5, 1'b0, '0);
        wait_idle();

        // Back-to-back with in_valid held.
        push_frame(8'hFF, 1'b0, 0);
        in_data = 8'hFF; err_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        push_frame(8'h00, 1'b0, 0);
        in_data = 8'h00;
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        if (!done) chk_fail("b2b_done_timeout");
        @(negedge clk);
        chk("b2b_gap_busy", busy, 1'b0);
        chk("b2b_gap_tx", tx_out, 1'b0);
        @(negedge clk);
        chk("b2b_second_start", busy, 1'b1);
        in_valid = 1'b0;
        wait_idle();

        // Fault injection on chip 2, hand-computed waveform.
        push_vec(v_3c);
        send(8'h3C, 1'b1, CW'(2));
        wait_idle();

        // Out-of-range fault chip behaves like no fault.
        push_frame(8'h81, 1'b0, 0);
        send(8'h81, 1'b1, CW'(7));
        wait_idle();

        // Reset mid-frame at frame cycle 23.
        push_frame(8'h55, 1'b0, 0);
        send(8'h55, 1'b0, '0);
        repeat (22) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_tx", tx_out, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_frame(8'h0F, 1'b0, 0);
        send(8'h0F, 1'b0, '0);
        wait_idle();

        // Input changes during a frame are ignored.
        push_frame(8'h12, 1'b0, 0);
        send(8'h12, 1'b0, '0);
        repeat (10) @(posedge clk);
        #1;
        in_data = 8'hFF; err_en = 1'b1; err_chip = CW'(0);
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("no_second_frame", busy, 1'b0);
        chk("sb_empty", sb.size() == 0, 1'b1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
